mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single core memory port between instruction fetch (IF) and the load/store path (LS). It arbitrates, latches one request, and drives the port's write_enable/read_enable/strb handshake until the memory responds. It returns read data, realigned to byte lane 0, to the winning requester. It also sits directly upstream of the per-access-type write-back masking and extension logic, and reports misaligned and timed-out accesses as faults.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles a granted access waits for mem_write_ready/mem_read_valid before it is aborted with a fault; legal range 1..65535.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held until if_done
if_addr  input  32  fetch address, word-aligned by construction
if_done  output  1  one-cycle completion pulse to fetch
if_rdata  output  32  fetched word, valid while if_done=1
if_fault  output  1  access fault, valid while if_done=1
ls_req  input  1  load/store request; held, with all ls_* fields stable, until ls_done
ls_addr  input  32  byte address
ls_access_type  input  4  common access encoding: SB, SH, SW, LB, LBU, LH, LHU, LW
ls_wdata  input  32  store data in lane 0
ls_done  output  1  one-cycle completion pulse to LS
ls_rdata  output  32  load data shifted down to lane 0, unextended
ls_fault  output  1  timeout fault, valid with ls_done
ls_misaligned  output  1  misalignment fault, valid with ls_done
mem_addr  output  32  port address, word-aligned ({addr[31:2],2'b00})
mem_wdata  output  32  store data shifted to byte lane addr[1:0]
mem_strb  output  4  byte strobe (0001/0011/1111) shifted left by addr[1:0]
mem_write_enable  output  1  write request, held until mem_write_ready
mem_write_ready  input  1  write accepted
mem_read_enable  output  1  read request, held until mem_read_valid
mem_read_valid  input  1  read data valid
mem_rdata  input  32  read data

Behaviour:
- Reset: state IDLE; last_grant=LS; all outputs 0; timeout counter 0. Reset mid-transaction drops the enables at the next edge. No done is ever produced for the abandoned access.
- Valid LS request: ls_req=1 and ls_access_type is one of SB/SH/SW/LB/LBU/LH/LHU/LW. Any other encoding is ignored, and no done is produced.
- Misalignment rule: the request is misaligned if it is a halfword access with addr[0]=1, or a word access with addr[1:0]!=0.
- States:
  - IDLE: no access in flight.
  - GRANT_IF: fetch access in flight.
  - GRANT_LS: load/store access in flight.
  - RESP: one cycle that drives the done pulse.
- IDLE, a single valid requester: grant it.
- IDLE, both requesting: grant the one not in last_grant (round-robin), then update last_grant.
- Grant latches address, type, data and requester into registers. All mem_* outputs are driven only from these registers.
- Misaligned LS request: no memory access is made. The next cycle is RESP with ls_done=1 and ls_misaligned=1.
- GRANT_x: mem_*_enable=1 from the cycle after the request is sampled. Completion is mem_read_valid (reads, fetch included) or mem_write_ready (writes), sampled on that edge. It can occur in the first enable cycle.
  - On completion: capture rdata (LS data >> 8*addr[1:0]), drop the enable, go to RESP.
- Timeout: the counter counts enable cycles without completion. On reaching TIMEOUT_CYCLES, drop the enable, go to RESP with fault=1 and rdata=0.
- RESP: the requester's done=1 for exactly one cycle, with rdata and the fault flags. Then IDLE; a new request sampled in RESP is not granted before IDLE.
- Minimum latency: request sampled at edge N, enable high in N+1, response in N+1, done high in N+2. Next grant is sampled at N+3.
- Requester deasserting req mid-access: the access still completes and done still pulses.
- Responses arriving in IDLE/RESP, or the wrong response type, are ignored.
- if_* outputs stay 0 during LS transactions, and vice versa.

Decomposition:
- common package gains:
  - arb_state_t: IDLE, GRANT_IF, GRANT_LS, RESP.
  - requester_t: REQ_IF, REQ_LS.
  - helper functions is_load(access_type) and is_store(access_type), reusing the existing SB..LW constants.
- One combinational sub-module, mem_lane_align. Input: access_type and addr[1:0]. Output: shifted strb, shifted wdata, misaligned flag, and read shift amount. The top module keeps the FSM, round-robin, timeout counter and response registers.

Test Plan:
- LW at 0x100 alone, memory returns 0xDEADBEEF with mem_read_valid in first enable cycle:
  - mem_read_enable=1 for 1 cycle, mem_addr=0x100.
  - ls_done at N+2, ls_rdata=0xDEADBEEF, no faults.
- SB at 0x203, wdata=0x000000A5, write_ready after 3 cycles:
  - mem_strb=1000, mem_wdata=0xA5000000, mem_addr=0x200, write_enable held 3 cycles.
  - ls_done one pulse.
- if_req and ls_req asserted together repeatedly, each answered in 1 cycle:
  - Grants alternate IF, LS, IF, ..., starting with IF after reset.
  - No done is ever lost.
- LH at 0x301:
  - No mem enable asserted.
  - ls_done=1, ls_misaligned=1 one cycle later.
- LBU at 0x402, mem_rdata=0x11223344:
  - mem_strb=0100, ls_rdata=0x00001122 (lane 2 → lane 0).
- TIMEOUT_CYCLES=4, read never answered:
  - mem_read_enable high exactly 4 cycles.
  - if_done=1, if_fault=1, if_rdata=0.
  - rst asserted mid-access in a rerun: enable=0 next cycle, no done.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared access-type encodings, arbiter state/requester enums
//               and small decode helpers for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Common load/store access encoding (bit 2 = load, bit 3 = unsigned load).
  localparam logic [3:0] c_SB  = 4'h0;
  localparam logic [3:0] c_SH  = 4'h1;
  localparam logic [3:0] c_SW  = 4'h2;
  localparam logic [3:0] c_LB  = 4'h4;
  localparam logic [3:0] c_LH  = 4'h5;
  localparam logic [3:0] c_LW  = 4'h6;
  localparam logic [3:0] c_LBU = 4'hC;
  localparam logic [3:0] c_LHU = 4'hD;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_LS = 2'd2,
    RESP     = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } requester_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } access_size_t;

  function automatic logic is_load(input logic [3:0] access_type);
    case (access_type)
      c_LB, c_LBU, c_LH, c_LHU, c_LW: is_load = 1'b1;
      default:                        is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] access_type);
    case (access_type)
      c_SB, c_SH, c_SW: is_store = 1'b1;
      default:          is_store = 1'b0;
    endcase
  endfunction

  // Access width; SZ_NONE marks an encoding that is not a legal access.
  function automatic access_size_t access_size(input logic [3:0] access_type);
    case (access_type)
      c_SB, c_LB, c_LBU: access_size = SZ_BYTE;
      c_SH, c_LH, c_LHU: access_size = SZ_HALF;
      c_SW, c_LW:        access_size = SZ_WORD;
      default:           access_size = SZ_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte-lane alignment for a load/store access:
//               strobe and store data shifted to lane addr[1:0], misalignment
//               detection and the read-data down-shift amount in bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [3:0]  i_access_type,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_strb,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  output logic [4:0]  o_rshift
);

  access_size_t w_size;
  logic [3:0]   w_base_strb;

  assign w_size = access_size(i_access_type);

  // Lane-0 strobe by size, then shift every lane-dependent quantity by addr[1:0].
  always_comb begin
    w_base_strb  = 4'b0000;
    o_misaligned = 1'b0;
    case (w_size)
      SZ_BYTE: w_base_strb = 4'b0001;
      SZ_HALF: begin
        w_base_strb  = 4'b0011;
        o_misaligned = i_addr_lo[0];
      end
      SZ_WORD: begin
        w_base_strb  = 4'b1111;
        o_misaligned = (i_addr_lo != 2'b00);
      end
      default: w_base_strb = 4'b0000;
    endcase
    o_strb   = w_base_strb << i_addr_lo;
    o_rshift = {i_addr_lo, 3'b000};
    o_wdata  = i_wdata << o_rshift;
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one memory port between fetch and
//               load/store. Latches the winning request, runs the enable /
//               ready-valid handshake with a timeout, and returns lane-0
//               aligned read data with fault flags as a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // fetch side
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        if_fault,
  // load/store side
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic [3:0]  ls_access_type,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        ls_fault,
  output logic        ls_misaligned,
  // memory port
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_strb,
  output logic        mem_write_enable,
  input  logic        mem_write_ready,
  output logic        mem_read_enable,
  input  logic        mem_read_valid,
  input  logic [31:0] mem_rdata
);

  localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_state_t  r_state;
  arb_state_t  w_state_next;
  requester_t  r_req;
  requester_t  r_last_grant;
  logic [29:0] r_word_addr;
  logic [3:0]  r_strb;
  logic [31:0] r_wdata;
  logic        r_is_store;
  logic [4:0]  r_rshift;
  logic [15:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_fault;
  logic        r_misaligned;

  logic        w_if_valid;
  logic        w_ls_is_store;
  logic        w_ls_valid;
  logic        w_grant_if;
  logic        w_grant_ls;
  logic        w_in_grant;
  logic        w_complete;
  logic        w_timeout;
  logic [3:0]  w_al_strb;
  logic [31:0] w_al_wdata;
  logic        w_al_misaligned;
  logic [4:0]  w_al_rshift;
  logic        w_unused_if_lo;

  // Fetch addresses are word-aligned by construction; low bits carry nothing.
  assign w_unused_if_lo = ^if_addr[1:0];

  mem_lane_align u_align (
    .i_access_type (ls_access_type),
    .i_addr_lo     (ls_addr[1:0]),
    .i_wdata       (ls_wdata),
    .o_strb        (w_al_strb),
    .o_wdata       (w_al_wdata),
    .o_misaligned  (w_al_misaligned),
    .o_rshift      (w_al_rshift)
  );

  // Request qualification and round-robin pick (prefer the one not served last).
  assign w_if_valid    = if_req;
  assign w_ls_is_store = is_store(ls_access_type);
  assign w_ls_valid    = ls_req && (is_load(ls_access_type) || w_ls_is_store);
  assign w_grant_if    = w_if_valid && (!w_ls_valid || (r_last_grant == REQ_LS));
  assign w_grant_ls    = w_ls_valid && !w_grant_if;

  // Handshake completion: writes finish on ready, reads (incl. fetch) on valid.
  assign w_in_grant = (r_state == GRANT_IF) || (r_state == GRANT_LS);
  assign w_complete = w_in_grant && (r_is_store ? mem_write_ready : mem_read_valid);
  assign w_timeout  = w_in_grant && (r_cnt == c_TIMEOUT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a misaligned LS grant skips the memory access entirely.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_if) begin
          w_state_next = GRANT_IF;
        end else if (w_grant_ls) begin
          w_state_next = w_al_misaligned ? RESP : GRANT_LS;
        end
      end
      GRANT_IF, GRANT_LS: begin
        if (w_complete || w_timeout) begin
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request latch at grant, timeout counting and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req        <= REQ_IF;
      r_last_grant <= REQ_LS;
      r_word_addr  <= '0;
      r_strb       <= '0;
      r_wdata      <= '0;
      r_is_store   <= 1'b0;
      r_rshift     <= '0;
      r_cnt        <= '0;
      r_rdata      <= '0;
      r_fault      <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_if) begin
            r_req        <= REQ_IF;
            r_last_grant <= REQ_IF;
            r_word_addr  <= if_addr[31:2];
            r_strb       <= 4'b1111;
            r_wdata      <= '0;
            r_is_store   <= 1'b0;
            r_rshift     <= '0;
            r_cnt        <= '0;
            r_rdata      <= '0;
            r_fault      <= 1'b0;
            r_misaligned <= 1'b0;
          end else if (w_grant_ls) begin
            r_req        <= REQ_LS;
            r_last_grant <= REQ_LS;
            r_word_addr  <= ls_addr[31:2];
            r_strb       <= w_al_strb;
            r_wdata      <= w_al_wdata;
            r_is_store   <= w_ls_is_store;
            r_rshift     <= w_al_rshift;
            r_cnt        <= '0;
            r_rdata      <= '0;
            r_fault      <= 1'b0;
            r_misaligned <= w_al_misaligned;
          end
        end
        GRANT_IF, GRANT_LS: begin
          if (w_complete) begin
            r_rdata <= r_is_store ? 32'd0 : (mem_rdata >> r_rshift);
          end else if (w_timeout) begin
            r_fault <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Memory port driven purely from the latched request and state.
  assign mem_addr         = {r_word_addr, 2'b00};
  assign mem_wdata        = r_wdata;
  assign mem_strb         = r_strb;
  assign mem_read_enable  = (r_state == GRANT_IF) || ((r_state == GRANT_LS) && !r_is_store);
  assign mem_write_enable = (r_state == GRANT_LS) && r_is_store;

  // Responses are gated to the owning requester so the other side reads zero.
  assign if_done       = (r_state == RESP) && (r_req == REQ_IF);
  assign if_rdata      = if_done ? r_rdata : 32'd0;
  assign if_fault      = if_done && r_fault;
  assign ls_done       = (r_state == RESP) && (r_req == REQ_LS);
  assign ls_rdata      = ls_done ? r_rdata : 32'd0;
  assign ls_fault      = ls_done && r_fault;
  assign ls_misaligned = ls_done && r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a latency-
//               configurable memory responder and directed access vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam logic [3:0] c_SB  = 4'h0;
  localparam logic [3:0] c_LH  = 4'h5;
  localparam logic [3:0] c_LW  = 4'h6;
  localparam logic [3:0] c_LBU = 4'hC;
  localparam logic [3:0] c_BAD = 4'hF;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_fault;
  logic        ls_req;
  logic [31:0] ls_addr;
  logic [3:0]  ls_access_type;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        ls_fault;
  logic        ls_misaligned;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic        mem_write_enable;
  logic        mem_write_ready;
  logic        mem_read_enable;
  logic        mem_read_valid;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .if_done          (if_done),
    .if_rdata         (if_rdata),
    .if_fault         (if_fault),
    .ls_req           (ls_req),
    .ls_addr          (ls_addr),
    .ls_access_type   (ls_access_type),
    .ls_wdata         (ls_wdata),
    .ls_done          (ls_done),
    .ls_rdata         (ls_rdata),
    .ls_fault         (ls_fault),
    .ls_misaligned    (ls_misaligned),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_strb         (mem_strb),
    .mem_write_enable (mem_write_enable),
    .mem_write_ready  (mem_write_ready),
    .mem_read_enable  (mem_read_enable),
    .mem_read_valid   (mem_read_valid),
    .mem_rdata        (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_ls;
    logic [31:0] rdata;
    logic        fault;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;

  // responder state
  int          mem_lat  = 1;
  logic [31:0] mem_data = 32'd0;
  int          en_cnt   = 0;
  int          last_en  = 0;
  int          en_total = 0;
  logic [31:0] seen_addr;
  logic [3:0]  seen_strb;
  logic [31:0] seen_wdata;
  logic        seen_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: answers the mem_lat-th enable cycle (0 = never answer).
  always @(negedge clk) begin
    if (mem_read_enable || mem_write_enable) begin
      if (en_cnt == 0) begin
        seen_addr  = mem_addr;
        seen_strb  = mem_strb;
        seen_wdata = mem_wdata;
        seen_we    = mem_write_enable;
      end
      en_cnt++;
      en_total++;
      mem_rdata = mem_data;
      if (mem_lat != 0 && en_cnt == mem_lat) begin
        mem_read_valid  = mem_read_enable;
        mem_write_ready = mem_write_enable;
      end else begin
        mem_read_valid  = 1'b0;
        mem_write_ready = 1'b0;
      end
    end else begin
      if (en_cnt != 0) last_en = en_cnt;
      en_cnt          = 0;
      mem_read_valid  = 1'b0;
      mem_write_ready = 1'b0;
    end
  end

  // Monitor: every done pulse pops one expected response.
  always @(negedge clk) begin
    if (if_done || ls_done) begin
      done_seen++;
      if (if_done && ls_done) chk("both_done", 32'd1, 32'd0);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got if_done=%0b ls_done=%0b, expected no done", if_done, ls_done);
      end else begin
        mon_e = sb_q.pop_front();
        chk("done_owner_is_ls", 32'(ls_done), 32'(mon_e.is_ls));
        if (mon_e.is_ls) begin
          chk("ls_rdata", ls_rdata, mon_e.rdata);
          chk("ls_fault", 32'(ls_fault), 32'(mon_e.fault));
          chk("ls_misaligned", 32'(ls_misaligned), 32'(mon_e.mis));
          chk("if_quiet_during_ls", {if_rdata[31:1], if_rdata[0] | if_fault}, 32'd0);
        end else begin
          chk("if_rdata", if_rdata, mon_e.rdata);
          chk("if_fault", 32'(if_fault), 32'(mon_e.fault));
          chk("ls_quiet_during_if", {ls_rdata[31:2], ls_rdata[1] | ls_fault, ls_rdata[0] | ls_misaligned}, 32'd0);
        end
      end
    end
  end

  task automatic push_exp(input logic is_ls, input logic [31:0] rd, input logic fault, input logic mis);
    exp_t e;
    e.is_ls = is_ls;
    e.rdata = rd;
    e.fault = fault;
    e.mis   = mis;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(if_done || ls_done) && cyc < 60);
    if (!(if_done || ls_done)) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected a done pulse", cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0;
    ls_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic ls_access(input logic [3:0] at, input logic [31:0] addr, input logic [31:0] wd,
                           input int lat, input logic [31:0] rd, output int cyc);
    mem_lat  = lat;
    mem_data = rd;
    @(negedge clk);
    ls_req         = 1'b1;
    ls_access_type = at;
    ls_addr        = addr;
    ls_wdata       = wd;
    wait_done(cyc);
    ls_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic if_access(input logic [31:0] addr, input int lat, input logic [31:0] rd, output int cyc);
    mem_lat  = lat;
    mem_data = rd;
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = addr;
    wait_done(cyc);
    if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int en0;
    int d0;
    int nd;
    int budget;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_addr = '0; ls_access_type = '0; ls_wdata = '0;
    mem_write_ready = 1'b0; mem_read_valid = 1'b0; mem_rdata = '0;
    do_reset();

    // reset state
    chk("rst_mem_enables", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_strb", 32'(mem_strb), 32'd0);
    chk("rst_dones", {30'd0, if_done, ls_done}, 32'd0);

    // LW 0x100, answered in the first enable cycle
    push_exp(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    ls_access(c_LW, 32'h0000_0100, 32'd0, 1, 32'hDEADBEEF, cyc);
    chk("lw_latency", 32'(cyc), 32'd2);
    chk("lw_en_cycles", 32'(last_en), 32'd1);
    chk("lw_mem_addr", seen_addr, 32'h0000_0100);
    chk("lw_is_read", 32'(seen_we), 32'd0);

    // SB 0x203, write accepted on the third enable cycle
    push_exp(1'b1, 32'd0, 1'b0, 1'b0);
    ls_access(c_SB, 32'h0000_0203, 32'h0000_00A5, 3, 32'd0, cyc);
    chk("sb_mem_addr", seen_addr, 32'h0000_0200);
    chk("sb_mem_strb", 32'(seen_strb), 32'h8);
    chk("sb_mem_wdata", seen_wdata, 32'hA500_0000);
    chk("sb_is_write", 32'(seen_we), 32'd1);
    chk("sb_en_cycles", 32'(last_en), 32'd3);

    // LH 0x301 is misaligned: no memory access, done one cycle later
    en0 = en_total;
    push_exp(1'b1, 32'd0, 1'b0, 1'b1);
    ls_access(c_LH, 32'h0000_0301, 32'd0, 1, 32'hFFFF_FFFF, cyc);
    chk("lh_mis_latency", 32'(cyc), 32'd1);
    chk("lh_mis_no_enable", 32'(en_total - en0), 32'd0);

    // LBU 0x402: lane 2 shifted down to lane 0
    push_exp(1'b1, 32'h0000_1122, 1'b0, 1'b0);
    ls_access(c_LBU, 32'h0000_0402, 32'd0, 1, 32'h1122_3344, cyc);
    chk("lbu_mem_strb", 32'(seen_strb), 32'h4);
    chk("lbu_mem_addr", seen_addr, 32'h0000_0400);

    // Illegal access type is ignored entirely
    en0 = en_total;
    d0  = done_seen;
    @(negedge clk);
    ls_req = 1'b1; ls_access_type = c_BAD; ls_addr = 32'h0000_0800;
    repeat (8) @(negedge clk);
    ls_req = 1'b0;
    chk("bad_type_no_enable", 32'(en_total - en0), 32'd0);
    chk("bad_type_no_done", 32'(done_seen - d0), 32'd0);

    // Both requesting continuously: IF first after reset, then alternate
    do_reset();
    mem_lat  = 1;
    mem_data = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, 32'h1234_5678, 1'b0, 1'b0);
      push_exp(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    end
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0600;
    ls_req = 1'b1; ls_access_type = c_LW; ls_addr = 32'h0000_0700;
    nd = 0;
    budget = 0;
    while (nd < 6 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (if_done || ls_done) nd++;
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    chk("rr_done_count", 32'(nd), 32'd6);
    repeat (4) @(negedge clk);

    // Fetch never answered: aborted after 4 enable cycles with a fault
    push_exp(1'b0, 32'd0, 1'b1, 1'b0);
    if_access(32'h0000_0500, 0, 32'hCAFE_F00D, cyc);
    chk("to_en_cycles", 32'(last_en), 32'd4);
    chk("to_is_read", 32'(seen_we), 32'd0);
    chk("to_latency", 32'(cyc), 32'd5);

    // Reset in the middle of an access: enable drops, no done
    d0 = done_seen;
    mem_lat = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0900;
    repeat (2) @(negedge clk);
    chk("midrst_en_before", 32'(mem_read_enable), 32'd1);
    rst = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    chk("midrst_en_after", 32'(mem_read_enable), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", 32'(done_seen - d0), 32'd0);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
